// File: rtl/tri_dispatch_scheduler.sv
// tri_dispatch_scheduler: sequences one frame of triangle pre-processing.
// On a start pulse it snapshots the camera and walks triangle IDs 0..count-1.
// For each ID it reads three vertices from the vertex BRAM and dispatches the
// triangle round-robin to one of NUM_UNITS pre_proc_shader units. It pulses
// frame_done_out once every dispatched triangle has left its unit.
//
// Ports:
//   clk_in, rst_in               clock, synchronous active-high reset
//   start_in, num_tri_in         frame start and triangle count (sampled in IDLE)
//   C_in, u_in, v_in, n_in       camera centre and basis (snapshotted at start)
//   busy_out, frame_done_out     frame in progress / one-cycle end-of-frame pulse
//   tri_rd_en_out, tri_addr_out  vertex BRAM read strobe and address
//   tri_data_in                  vertex BRAM data, RD_LATENCY cycles after strobe
//   unit_ready_in                per-unit ready
//   unit_valid_out               per-unit valid (one-hot or zero)
//   unit_tri_id_out, unit_P_out  broadcast triangle ID and vertices
//   unit_C/u/v/n_out             broadcast camera snapshot
module tri_dispatch_scheduler #(
    parameter int unsigned NUM_TRI    = 2048,
    parameter int unsigned NUM_UNITS  = 4,
    parameter int unsigned P_WIDTH    = 16,
    parameter int unsigned C_WIDTH    = 18,
    parameter int unsigned V_WIDTH    = 16,
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          start_in,
    input  logic [$clog2(NUM_TRI):0]      num_tri_in,
    input  logic signed [3*C_WIDTH-1:0]   C_in,
    input  logic signed [3*V_WIDTH-1:0]   u_in,
    input  logic signed [3*V_WIDTH-1:0]   v_in,
    input  logic signed [3*V_WIDTH-1:0]   n_in,
    output logic                          busy_out,
    output logic                          frame_done_out,
    output logic                          tri_rd_en_out,
    output logic [$clog2(NUM_TRI)-1:0]    tri_addr_out,
    input  logic [9*P_WIDTH-1:0]          tri_data_in,
    input  logic [NUM_UNITS-1:0]          unit_ready_in,
    output logic [NUM_UNITS-1:0]          unit_valid_out,
    output logic [$clog2(NUM_TRI)-1:0]    unit_tri_id_out,
    output logic [9*P_WIDTH-1:0]          unit_P_out,
    output logic signed [3*C_WIDTH-1:0]   unit_C_out,
    output logic signed [3*V_WIDTH-1:0]   unit_u_out,
    output logic signed [3*V_WIDTH-1:0]   unit_v_out,
    output logic signed [3*V_WIDTH-1:0]   unit_n_out
);

    localparam int unsigned ID_W   = $clog2(NUM_TRI);
    localparam int unsigned CNT_W  = ID_W + 1;
    localparam int unsigned UNIT_W = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned LAT_W  = $clog2(RD_LATENCY + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DISPATCH,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic [CNT_W-1:0]             r_count;
    logic [CNT_W-1:0]             r_index;
    logic [LAT_W-1:0]             r_wait_cnt;
    logic [UNIT_W-1:0]            r_rr;
    logic [NUM_UNITS-1:0]         r_busy;
    logic [NUM_UNITS-1:0]         r_seen_low;
    logic [9*P_WIDTH-1:0]         r_stage;
    logic [ID_W-1:0]              r_tri_id;
    logic [ID_W-1:0]              r_addr;
    logic                         r_rd_en;
    logic [NUM_UNITS-1:0]         r_valid;
    logic                         r_busy_out;
    logic                         r_done;
    logic signed [3*C_WIDTH-1:0]  r_snap_c;
    logic signed [3*V_WIDTH-1:0]  r_snap_u;
    logic signed [3*V_WIDTH-1:0]  r_snap_v;
    logic signed [3*V_WIDTH-1:0]  r_snap_n;

    logic [CNT_W-1:0]             w_num_clamped;
    logic                         w_last;
    logic                         w_found;
    logic [UNIT_W-1:0]            w_sel;
    logic [UNIT_W-1:0]            w_cand;
    logic [UNIT_W-1:0]            w_rr_next;
    logic [NUM_UNITS-1:0]         w_onehot;
    logic [NUM_UNITS-1:0]         w_set;
    logic [NUM_UNITS-1:0]         w_clr;
    logic                         w_accept;
    logic                         w_capture;
    logic                         w_dispatch;

    assign w_num_clamped = (num_tri_in > CNT_W'(NUM_TRI)) ? CNT_W'(NUM_TRI) : num_tri_in;
    assign w_last        = ((r_index + CNT_W'(1)) == r_count);

    // Round-robin search from r_rr for the first ready, non-busy unit.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        for (int i = 0; i < int'(NUM_UNITS); i++) begin
            if ((int'(r_rr) + i) >= int'(NUM_UNITS)) begin
                w_cand = UNIT_W'(int'(r_rr) + i - int'(NUM_UNITS));
            end else begin
                w_cand = UNIT_W'(int'(r_rr) + i);
            end
            if (!w_found && unit_ready_in[w_cand] && !r_busy[w_cand]) begin
                w_found = 1'b1;
                w_sel   = w_cand;
            end
        end
    end

    assign w_rr_next = (w_sel == UNIT_W'(NUM_UNITS - 1)) ? '0 : (w_sel + UNIT_W'(1));
    assign w_onehot  = NUM_UNITS'(1) << w_sel;
    assign w_set     = w_dispatch ? w_onehot : '0;
    // A unit is released only after it has been seen not-ready and then ready again.
    assign w_clr     = r_busy & r_seen_low & unit_ready_in;

    // State register.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and control strobes.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_dispatch   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_accept     = 1'b1;
                    w_state_next = (w_num_clamped == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == LAT_W'(RD_LATENCY)) begin
                    w_capture    = 1'b1;
                    w_state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (w_found) begin
                    w_dispatch   = 1'b1;
                    w_state_next = w_last ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (r_busy == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_count    <= '0;
            r_index    <= '0;
            r_wait_cnt <= '0;
            r_rr       <= '0;
            r_busy     <= '0;
            r_seen_low <= '0;
            r_stage    <= '0;
            r_tri_id   <= '0;
            r_addr     <= '0;
            r_rd_en    <= 1'b0;
            r_valid    <= '0;
            r_busy_out <= 1'b0;
            r_done     <= 1'b0;
            r_snap_c   <= '0;
            r_snap_u   <= '0;
            r_snap_v   <= '0;
            r_snap_n   <= '0;
        end else begin
            r_rd_en    <= (w_state_next == S_FETCH);
            r_done     <= (w_state_next == S_DONE);
            r_valid    <= w_set;
            r_busy     <= (r_busy & ~w_clr) | w_set;
            r_seen_low <= (r_seen_low | (r_busy & ~unit_ready_in)) & ~w_clr;

            if (w_accept) begin
                r_snap_c   <= C_in;
                r_snap_u   <= u_in;
                r_snap_v   <= v_in;
                r_snap_n   <= n_in;
                r_count    <= w_num_clamped;
                r_index    <= '0;
                r_addr     <= '0;
                r_busy_out <= 1'b1;
            end

            // busy_out stays high through the done cycle and drops after it.
            if (r_state == S_DONE) begin
                r_busy_out <= 1'b0;
            end

            if (r_state == S_FETCH) begin
                r_wait_cnt <= LAT_W'(1);
            end else if (r_state == S_WAIT) begin
                r_wait_cnt <= r_wait_cnt + LAT_W'(1);
            end

            if (w_capture) begin
                r_stage <= tri_data_in;
            end

            if (w_dispatch) begin
                r_tri_id <= ID_W'(r_index);
                r_index  <= r_index + CNT_W'(1);
                r_addr   <= ID_W'(r_index + CNT_W'(1));
                r_rr     <= w_rr_next;
            end
        end
    end

    assign busy_out        = r_busy_out;
    assign frame_done_out  = r_done;
    assign tri_rd_en_out   = r_rd_en;
    assign tri_addr_out    = r_addr;
    assign unit_valid_out  = r_valid;
    assign unit_tri_id_out = r_tri_id;
    assign unit_P_out      = r_stage;
    assign unit_C_out      = r_snap_c;
    assign unit_u_out      = r_snap_u;
    assign unit_v_out      = r_snap_v;
    assign unit_n_out      = r_snap_n;

endmodule

// File: tb/tb_tri_dispatch_scheduler.sv
// Directed testbench for tri_dispatch_scheduler: vertex BRAM model, shader unit
// models with programmable processing time / hold-off, dispatch logging.
module tb_tri_dispatch_scheduler;

    localparam int NUM_TRI    = 2048;
    localparam int NUM_UNITS  = 4;
    localparam int P_WIDTH    = 16;
    localparam int C_WIDTH    = 18;
    localparam int V_WIDTH    = 16;
    localparam int RD_LATENCY = 2;
    localparam int ID_W       = $clog2(NUM_TRI);

    logic                        clk_in;
    logic                        rst_in;
    logic                        start_in;
    logic [ID_W:0]               num_tri_in;
    logic signed [3*C_WIDTH-1:0] C_in;
    logic signed [3*V_WIDTH-1:0] u_in;
    logic signed [3*V_WIDTH-1:0] v_in;
    logic signed [3*V_WIDTH-1:0] n_in;
    logic                        busy_out;
    logic                        frame_done_out;
    logic                        tri_rd_en_out;
    logic [ID_W-1:0]             tri_addr_out;
    logic [9*P_WIDTH-1:0]        tri_data_in;
    logic [NUM_UNITS-1:0]        unit_ready_in;
    logic [NUM_UNITS-1:0]        unit_valid_out;
    logic [ID_W-1:0]             unit_tri_id_out;
    logic [9*P_WIDTH-1:0]        unit_P_out;
    logic signed [3*C_WIDTH-1:0] unit_C_out;
    logic signed [3*V_WIDTH-1:0] unit_u_out;
    logic signed [3*V_WIDTH-1:0] unit_v_out;
    logic signed [3*V_WIDTH-1:0] unit_n_out;

    tri_dispatch_scheduler #(
        .NUM_TRI    (NUM_TRI),
        .NUM_UNITS  (NUM_UNITS),
        .P_WIDTH    (P_WIDTH),
        .C_WIDTH    (C_WIDTH),
        .V_WIDTH    (V_WIDTH),
        .RD_LATENCY (RD_LATENCY)
    ) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .start_in        (start_in),
        .num_tri_in      (num_tri_in),
        .C_in            (C_in),
        .u_in            (u_in),
        .v_in            (v_in),
        .n_in            (n_in),
        .busy_out        (busy_out),
        .frame_done_out  (frame_done_out),
        .tri_rd_en_out   (tri_rd_en_out),
        .tri_addr_out    (tri_addr_out),
        .tri_data_in     (tri_data_in),
        .unit_ready_in   (unit_ready_in),
        .unit_valid_out  (unit_valid_out),
        .unit_tri_id_out (unit_tri_id_out),
        .unit_P_out      (unit_P_out),
        .unit_C_out      (unit_C_out),
        .unit_u_out      (unit_u_out),
        .unit_v_out      (unit_v_out),
        .unit_n_out      (unit_n_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Vertex memory contents: each coordinate word is unique per (ID, word).
    function automatic logic [9*P_WIDTH-1:0] mem_word(input int a);
        logic [9*P_WIDTH-1:0] w;
        w = '0;
        for (int v = 0; v < 9; v++) begin
            w[v*P_WIDTH +: P_WIDTH] = P_WIDTH'(a * 9 + v + 1);
        end
        return w;
    endfunction

    // BRAM with two-cycle read latency; zero when no read was issued.
    logic [9*P_WIDTH-1:0] rd_pipe = '0;
    initial tri_data_in = '0;
    always @(posedge clk_in) begin
        rd_pipe     <= tri_rd_en_out ? mem_word(int'(tri_addr_out)) : '0;
        tri_data_in <= rd_pipe;
    end

    // Shader units: ready drops for proc_len cycles after each accepted triangle.
    int                   proc_len = 3;
    logic [NUM_UNITS-1:0] hold = '0;
    int                   ucnt [NUM_UNITS];
    initial for (int k = 0; k < NUM_UNITS; k++) ucnt[k] = 0;

    always_comb begin
        unit_ready_in = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            unit_ready_in[k] = !hold[k] && (ucnt[k] == 0);
        end
    end

    always @(posedge clk_in) begin
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (unit_valid_out[k] && unit_ready_in[k]) ucnt[k] <= proc_len;
            else if (ucnt[k] > 0) ucnt[k] <= ucnt[k] - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    // Dispatch / read / done log, sampled on the falling edge.
    int                          disp_unit [$];
    int                          disp_id   [$];
    int                          disp_cyc  [$];
    int                          rd_cnt   = 0;
    int                          done_cnt = 0;
    int                          done_cyc = 0;
    int                          start_cyc = 0;
    logic signed [3*C_WIDTH-1:0] exp_c = '0;
    logic signed [3*V_WIDTH-1:0] exp_n = '0;

    always @(negedge clk_in) begin
        int u;
        u = 0;
        if (unit_valid_out != '0) begin
            check("valid_onehot", 160'($onehot(unit_valid_out)), 160'(1));
            for (int k = 0; k < NUM_UNITS; k++) if (unit_valid_out[k]) u = k;
            check("ready_at_valid", 160'(unit_ready_in[u]), 160'(1));
            check("unit_P", 160'(unit_P_out), 160'(mem_word(int'(unit_tri_id_out))));
            check("snap_C", 160'(unit_C_out), 160'(exp_c));
            check("snap_n", 160'(unit_n_out), 160'(exp_n));
            disp_unit.push_back(u);
            disp_id.push_back(int'(unit_tri_id_out));
            disp_cyc.push_back(cyc);
        end
        if (tri_rd_en_out) begin
            check("rd_addr", 160'(tri_addr_out), 160'(rd_cnt));
            rd_cnt++;
        end
        if (frame_done_out) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic tick();
        @(negedge clk_in);
        #1;
    endtask

    task automatic clear_log();
        disp_unit.delete();
        disp_id.delete();
        disp_cyc.delete();
        rd_cnt   = 0;
        done_cnt = 0;
    endtask

    task automatic start_frame(input int n);
        tick();
        num_tri_in = (ID_W + 1)'(n);
        start_in   = 1'b1;
        exp_c      = C_in;
        exp_n      = n_in;
        tick();
        start_in   = 1'b0;
        start_cyc  = cyc;
    endtask

    task automatic wait_done(input int max_cyc);
        int i;
        i = 0;
        while (done_cnt == 0 && i < max_cyc) begin
            tick();
            i++;
        end
        check("done_seen", 160'(done_cnt != 0), 160'(1));
        check("busy_at_done", 160'(busy_out), 160'(1));
        tick();
        check("busy_after_done", 160'(busy_out), 160'(0));
    endtask

    task automatic wait_disp(input int n, input int max_cyc);
        int i;
        i = 0;
        while (disp_unit.size() < n && i < max_cyc) begin
            tick();
            i++;
        end
        check("disp_reached", 160'(disp_unit.size() >= n), 160'(1));
    endtask

    task automatic check_order(input string tag, input int n, input int units [8]);
        check({tag, "_count"}, 160'(disp_unit.size()), 160'(n));
        for (int i = 0; i < n && i < disp_unit.size(); i++) begin
            check({tag, "_unit"}, 160'(disp_unit[i]), 160'(units[i]));
            check({tag, "_id"}, 160'(disp_id[i]), 160'(i));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int units [8];
        rst_in     = 1'b1;
        start_in   = 1'b0;
        num_tri_in = '0;
        C_in       = 54'sh12345_6789ABC;
        u_in       = 48'sh0001_0000_0000;
        v_in       = 48'sh0000_0001_0000;
        n_in       = 48'sh1111_2222_3333;
        repeat (3) tick();
        check("rst_busy", 160'(busy_out), 160'(0));
        check("rst_done", 160'(frame_done_out), 160'(0));
        check("rst_rd_en", 160'(tri_rd_en_out), 160'(0));
        check("rst_valid", 160'(unit_valid_out), 160'(0));
        check("rst_C", 160'(unit_C_out), 160'(0));
        rst_in = 1'b0;
        tick();

        // Empty frame: straight to done, no reads, no dispatches.
        clear_log();
        start_frame(0);
        check("t0_busy", 160'(busy_out), 160'(1));
        wait_done(10);
        check("t0_done_lat", 160'(done_cyc - start_cyc), 160'(1));
        check("t0_reads", 160'(rd_cnt), 160'(0));
        check("t0_disp", 160'(disp_unit.size()), 160'(0));

        // Eight triangles, all units ready; camera changes and a stray start mid-frame.
        clear_log();
        proc_len = 3;
        start_frame(8);
        wait_disp(3, 100);
        C_in       = 54'sh0DEAD_BEEF000;
        n_in       = 48'sh7777_8888_9999;
        num_tri_in = (ID_W + 1)'(2);
        start_in   = 1'b1;
        tick();
        start_in   = 1'b0;
        wait_done(200);
        units = '{0, 1, 2, 3, 0, 1, 2, 3};
        check_order("t2", 8, units);
        check("t2_reads", 160'(rd_cnt), 160'(8));
        if (disp_cyc.size() == 8) check("t2_drain_lat", 160'(done_cyc - disp_cyc[7]), 160'(6));
        check("t2_C_held", 160'(unit_C_out), 160'(54'sh12345_6789ABC));
        check("t2_n_held", 160'(unit_n_out), 160'(48'sh1111_2222_3333));
        repeat (10) tick();
        check("t2_done_cnt", 160'(done_cnt), 160'(1));
        check("t2_idle", 160'(busy_out), 160'(0));

        // Units 0 and 2 held off, long processing forces a stall.
        clear_log();
        hold     = 4'b0101;
        proc_len = 10;
        start_frame(4);
        wait_done(300);
        units = '{1, 3, 1, 3, 0, 0, 0, 0};
        check_order("t3", 4, units);
        if (disp_cyc.size() == 4) begin
            check("t3_stall_gap", 160'(disp_cyc[2] - disp_cyc[0]), 160'(13));
            check("t3_drain_lat", 160'(done_cyc - disp_cyc[3]), 160'(13));
        end
        hold = '0;

        // Short-circuiting units: ready low for a single cycle.
        clear_log();
        proc_len = 1;
        start_frame(5);
        wait_done(100);
        units = '{0, 1, 2, 3, 0, 0, 0, 0};
        check_order("t4", 5, units);
        if (disp_cyc.size() == 5) check("t4_drain_lat", 160'(done_cyc - disp_cyc[4]), 160'(4));
        check("t4_done_cnt", 160'(done_cnt), 160'(1));

        // Count above NUM_TRI clamps to NUM_TRI; last ID is NUM_TRI-1.
        clear_log();
        proc_len = 3;
        start_frame(3000);
        wait_done(10000);
        check("t5_disp", 160'(disp_unit.size()), 160'(NUM_TRI));
        if (disp_id.size() > 0) begin
            check("t5_first_id", 160'(disp_id[0]), 160'(0));
            check("t5_last_id", 160'(disp_id[disp_id.size()-1]), 160'(NUM_TRI - 1));
        end
        check("t5_reads", 160'(rd_cnt), 160'(NUM_TRI));
        check("t5_done_cnt", 160'(done_cnt), 160'(1));

        // Reset while dispatching with three units busy.
        clear_log();
        proc_len = 20;
        start_frame(8);
        wait_disp(3, 100);
        repeat (3) tick();
        rst_in = 1'b1;
        tick();
        check("t6_busy", 160'(busy_out), 160'(0));
        check("t6_valid", 160'(unit_valid_out), 160'(0));
        check("t6_rd_en", 160'(tri_rd_en_out), 160'(0));
        check("t6_done", 160'(frame_done_out), 160'(0));
        check("t6_addr", 160'(tri_addr_out), 160'(0));
        check("t6_id", 160'(unit_tri_id_out), 160'(0));
        check("t6_P", 160'(unit_P_out), 160'(0));
        check("t6_C", 160'(unit_C_out), 160'(0));
        check("t6_n", 160'(unit_n_out), 160'(0));
        check("t6_disp", 160'(disp_unit.size()), 160'(3));
        rst_in = 1'b0;
        repeat (30) tick();
        check("t6_no_done", 160'(done_cnt), 160'(0));
        clear_log();
        proc_len = 3;
        start_frame(2);
        wait_done(100);
        units = '{0, 1, 0, 0, 0, 0, 0, 0};
        check_order("t6b", 2, units);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/tri_dispatch_scheduler.md
Name: tri_dispatch_scheduler

Overview:
- Sequences one frame of triangle pre-processing.
- On a start pulse it snapshots the camera, walks triangle IDs 0..num_tri_in-1, and reads each triangle's three vertices from vertex BRAM.
- Each triangle is dispatched to one of NUM_UNITS parallel pre_proc_shader instances with round-robin arbitration over their valid/ready handshakes.
- It signals frame completion once every dispatched triangle has left its unit. It sits between the frame controller/vertex memory and the pre_proc_shader bank.

Parameters:
- NUM_TRI, 2048, max triangles in vertex memory; ID width is $clog2(NUM_TRI).
- NUM_UNITS, 4, number of pre_proc_shader instances served (>=1).
- P_WIDTH, 16, vertex coordinate width.
- C_WIDTH, 18, camera centre width.
- V_WIDTH, 16, camera basis vector width.
- RD_LATENCY, 2, vertex BRAM read latency in cycles (>=1).

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  synchronous active-high reset.
- start_in  in  1  begin frame; sampled only in IDLE.
- num_tri_in  in  $clog2(NUM_TRI)+1  triangles this frame; sampled with start_in; values above NUM_TRI are clamped to NUM_TRI.
- C_in  in  3*C_WIDTH signed  camera centre.
- u_in, v_in, n_in  in  3*V_WIDTH signed each  camera basis.
- busy_out  out  1  high from accepted start until the done pulse, inclusive.
- frame_done_out  out  1  one-cycle pulse at frame end.
- tri_rd_en_out  out  1  BRAM read strobe.
- tri_addr_out  out  $clog2(NUM_TRI)  BRAM address (= triangle ID).
- tri_data_in  in  9*P_WIDTH  vertex data [v][axis], valid RD_LATENCY cycles after the strobe.
- unit_ready_in  in  NUM_UNITS  per-unit ready_out.
- unit_valid_out  out  NUM_UNITS  one-hot (or zero) per-unit valid_in.
- unit_tri_id_out  out  $clog2(NUM_TRI)  broadcast triangle ID.
- unit_P_out  out  9*P_WIDTH  broadcast vertices.
- unit_C_out, unit_u_out, unit_v_out, unit_n_out  out  as inputs  camera snapshot.

Behaviour:
- Reset: all outputs 0, state IDLE, rr pointer 0, busy flags 0. Reset mid-frame abandons the frame with no done pulse.
- States: IDLE, FETCH, WAIT, DISPATCH, DRAIN, DONE.
- IDLE:
  - start_in=1: latch C/u/v/n into snapshot registers (held constant until the next start), latch count, clear tri index, set busy_out=1.
  - Next state is FETCH, or DRAIN if count==0.
- FETCH: assert tri_rd_en_out for exactly one cycle with tri_addr_out=index, then go to WAIT.
- WAIT: count RD_LATENCY cycles, capture tri_data_in into the staging register, go to DISPATCH.
- DISPATCH:
  - Search units starting at rr, wrapping modulo NUM_UNITS, for the first k with unit_ready_in[k]=1 and busy[k]=0.
  - If found: assert unit_valid_out[k] for one cycle with staging data and ID on the broadcast buses; set busy[k]; set rr=(k+1) mod NUM_UNITS; increment index.
  - After dispatch: if index==count go to DRAIN, else go to FETCH.
  - If none found: hold with all valids 0 and re-evaluate every cycle.
- Dispatch timing: valid is registered; exactly one unit is valid per dispatch. Broadcast buses stay stable while any unit_valid_out bit is high.
- Busy tracking (covers units that short-circuit and never raise valid_out):
  - Per unit: a seen_low bit is set when busy[k] and unit_ready_in[k]==0.
  - busy[k] and seen_low[k] clear when unit_ready_in[k]==1 and seen_low[k].
- DRAIN: wait until busy==0, then go to DONE.
- DONE: frame_done_out=1 for one cycle, busy_out drops the next cycle, go to IDLE.
- Throughput: at most one dispatch per RD_LATENCY+2 cycles. No prefetch overlap.
- start_in while not in IDLE is ignored. A start_in coincident with the done pulse is ignored.
- Index wraps nowhere: a frame with count==NUM_TRI ends after ID NUM_TRI-1.

Test Plan:
- Reset then start with num_tri_in=0 -> no tri_rd_en_out, no unit valid; frame_done_out pulses within 3 cycles; busy_out then 0.
- NUM_UNITS=4, all units ready with 3-cycle fake processing, num_tri_in=8 -> IDs 0..7 dispatched to units 0,1,2,3,0,1,2,3; tri_addr_out matches ID; one done pulse after the last unit returns ready.
- Units 0 and 2 held not-ready -> dispatches alternate 1,3,1,3; the scheduler stalls with valid=0 while all are busy.
- Unit model short-circuits (ready low 1 cycle, no valid_out) on every triangle, num_tri_in=5 -> all 5 dispatched and frame_done_out still pulses.
- Change C_in/n_in mid-frame -> unit_C_out/unit_n_out keep start-time values; start_in during the frame is ignored.
- Assert rst_in during DISPATCH with 3 busy units -> next cycle all outputs 0, no done pulse; a fresh start with num_tri_in=2 dispatches IDs 0,1 from unit 0.
